// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one sram-like slave port between the instruction
// and data sram-like masters of the core. Only one transaction is in flight at
// a time. The grant is made one cycle before the address phase starts. A
// transaction that completes can hand the bus straight to the next requester
// with no idle cycle in between.
`timescale 1ns/1ps

module sram_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter bit RR_ENABLE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  // instruction master
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  // data master
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  // shared slave port
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt_s;
  logic   owner_r;          // 0 = inst, 1 = data
  logic   owner_nxt_s;
  logic   last_owner_r;
  logic   last_owner_nxt_s;
  logic   arb_s;
  logic   any_req_s;

  assign any_req_s = inst_req | data_req;

  // Read data goes to both masters; each qualifies it with its own data_ok.
  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

  // Arbitration: a lone requester wins; on a tie data wins, or the master
  // not granted last time wins when round-robin is enabled.
  always_comb begin
    arb_s = 1'b0;
    if (data_req && !inst_req) begin
      arb_s = 1'b1;
    end else if (inst_req && !data_req) begin
      arb_s = 1'b0;
    end else if (RR_ENABLE) begin
      arb_s = ~last_owner_r;
    end else begin
      arb_s = 1'b1;
    end
  end

  // Next-state and grant logic.
  always_comb begin
    state_nxt_s      = state_r;
    owner_nxt_s      = owner_r;
    last_owner_nxt_s = last_owner_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_nxt_s      = ADDR;
          owner_nxt_s      = arb_s;
          last_owner_nxt_s = arb_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ADDR: begin
        // A data_ok seen here is stale and deliberately ignored.
        if (bus_addr_ok) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = ADDR;
        end
      end
      DATA: begin
        if (bus_data_ok) begin
          if (any_req_s) begin
            state_nxt_s      = ADDR;
            owner_nxt_s      = arb_s;
            last_owner_nxt_s = arb_s;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, owner and round-robin history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      owner_r      <= 1'b0;
      last_owner_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      owner_r      <= owner_nxt_s;
      last_owner_r <= last_owner_nxt_s;
    end
  end

  // Bus request/attribute mux and handshake routing to the owner only.
  always_comb begin
    bus_req      = 1'b0;
    bus_wr       = 1'b0;
    bus_size     = 2'b00;
    bus_addr     = {ADDR_W{1'b0}};
    bus_wdata    = {DATA_W{1'b0}};
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    if (!rst) begin
      case (state_r)
        ADDR: begin
          bus_req = 1'b1;
          if (owner_r) begin
            bus_wr       = data_wr;
            bus_size     = data_size;
            bus_addr     = data_addr;
            bus_wdata    = data_wdata;
            data_addr_ok = bus_addr_ok;
          end else begin
            bus_wr       = inst_wr;
            bus_size     = inst_size;
            bus_addr     = inst_addr;
            bus_wdata    = inst_wdata;
            inst_addr_ok = bus_addr_ok;
          end
        end
        DATA: begin
          if (owner_r) begin
            data_data_ok = bus_data_ok;
          end else begin
            inst_data_ok = bus_data_ok;
          end
        end
        IDLE: begin
          bus_req = 1'b0;
        end
        default: begin
          bus_req = 1'b0;
        end
      endcase
    end else begin
      bus_req = 1'b0;
    end
  end

endmodule
